// File: rtl/reg_file_if.sv
// reg_file_if: bundles the register-file read, write, debug and count
// signals so the datapath and the bench connect through one port.
//
// Signals
//   ReadReg1/ReadReg2  read indices (rs, rt)
//   WriteReg           write index from the RegDst mux
//   WriteData          write value from the MemtoReg mux
//   RegWrite           write enable from the control unit
//   DbgReg             debug read index
//   ReadData1/2        read data for ReadReg1/ReadReg2
//   DbgData            read data for DbgReg
//   WriteCount         committed writes since reset (saturating)
//
// Modports
//   master  datapath / bench side: drives indices and write data
//   slave   register file side: returns read data and the count
interface reg_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
);
  logic [ADDR_WIDTH-1:0] ReadReg1;
  logic [ADDR_WIDTH-1:0] ReadReg2;
  logic [ADDR_WIDTH-1:0] WriteReg;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] DbgReg;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;
  logic [DATA_WIDTH-1:0] DbgData;
  logic [CNT_WIDTH-1:0]  WriteCount;

  modport master (
    output ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite, DbgReg,
    input  ReadData1, ReadData2, DbgData, WriteCount
  );

  modport slave (
    input  ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite, DbgReg,
    output ReadData1, ReadData2, DbgData, WriteCount
  );
endinterface

// File: rtl/reg_file.sv
// reg_file: 32-entry general-purpose register file for the MIPS
// single-cycle datapath. Two combinational read ports (rs, rt), one
// synchronous write port, a combinational debug read port and a
// saturating committed-write counter.
//
// Ports
//   Clk      system clock, all state changes on the rising edge
//   Reset_n  asynchronous active-low reset; clears every register to 0
//            except $sp (reg 29), which loads SP_RESET; clears WriteCount
//   bus      reg_file_if.slave: indices, write data/enable, read data,
//            debug data and WriteCount
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a read index matching an active
//                      write (RegWrite=1, WriteReg!=0) returns WriteData
//                      in the same cycle on ReadData1, ReadData2 and
//                      DbgData. When undefined, reads return the stored
//                      value until the commit edge and WriteData has no
//                      combinational path to any read output.
module reg_file #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    CNT_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] SP_RESET   = 32'h7FFF_EFFC
) (
  input  logic        Clk,
  input  logic        Reset_n,
  reg_file_if.slave   bus
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int SP_IDX   = 29;

  // Entry 0 has no storage; the array starts at 1.
  logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];
  // Read view with the hardwired zero in slot 0, indexed directly by the
  // read ports.
  logic [DATA_WIDTH-1:0] view [NUM_REGS];
  logic [CNT_WIDTH-1:0]  wcount;
  logic                  commit;

  // A write to index 0 is discarded and never counted.
  assign commit = bus.RegWrite && (bus.WriteReg != '0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
    end else if (commit) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (bus.WriteReg == ADDR_WIDTH'(i)) begin
          regs[i] <= bus.WriteData;
        end
      end
    end
  end

  // Saturates at all-ones so a long trace never wraps back to a small count.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wcount <= '0;
    end else if (commit && (wcount != '1)) begin
      wcount <= wcount + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    view[0] = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      view[i] = regs[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic hit1;
  logic hit2;
  logic hitd;

  // commit already excludes index 0, so reg 0 can never be bypassed.
  assign hit1 = commit && (bus.ReadReg1 == bus.WriteReg);
  assign hit2 = commit && (bus.ReadReg2 == bus.WriteReg);
  assign hitd = commit && (bus.DbgReg   == bus.WriteReg);

  assign bus.ReadData1 = hit1 ? bus.WriteData : view[bus.ReadReg1];
  assign bus.ReadData2 = hit2 ? bus.WriteData : view[bus.ReadReg2];
  assign bus.DbgData   = hitd ? bus.WriteData : view[bus.DbgReg];
`else
  assign bus.ReadData1 = view[bus.ReadReg1];
  assign bus.ReadData2 = view[bus.ReadReg2];
  assign bus.DbgData   = view[bus.DbgReg];
`endif

  assign bus.WriteCount = wcount;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file. Stimulus changes inputs 1 time unit after
// a rising edge and queues the expected port values; the monitor samples
// and compares them on the following falling edge.
module tb_reg_file;

  localparam logic [31:0] SP_VAL = 32'h7FFF_EFFC;
  localparam int P_RD1 = 0;
  localparam int P_RD2 = 1;
  localparam int P_DBG = 2;
  localparam int P_CNT = 3;

  typedef struct {
    int          port;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic Clk;
  logic Reset_n;

  reg_file_if bus ();

  reg_file dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", sb.size());
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  always @(negedge Clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.port)
        P_RD1:   act = bus.ReadData1;
        P_RD2:   act = bus.ReadData2;
        P_DBG:   act = bus.DbgData;
        default: act = 32'(bus.WriteCount);
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_val(input int port, input logic [31:0] v, input string nm);
    exp_t e;
    e.port = port;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.RegWrite  = 1'b1;
    bus.WriteReg  = a;
    bus.WriteData = d;
  endtask

  logic [31:0] rdw_pre;

  initial begin
    Reset_n       = 1'b0;
    bus.ReadReg1  = '0;
    bus.ReadReg2  = '0;
    bus.DbgReg    = '0;
    bus.WriteReg  = '0;
    bus.WriteData = '0;
    bus.RegWrite  = 1'b0;
    step();
    step();
    Reset_n = 1'b1;

    // Power-on state.
    bus.ReadReg1 = 5'd29;
    bus.ReadReg2 = 5'd0;
    bus.DbgReg   = 5'd8;
    expect_val(P_RD1, SP_VAL, "por_sp");
    expect_val(P_RD2, 32'h0, "por_r0");
    expect_val(P_DBG, 32'h0, "por_r8");
    expect_val(P_CNT, 32'h0, "por_cnt");
    step();

    // Basic write/read.
    wr(5'd8, 32'hDEAD_BEEF);
    step();
    wr(5'd9, 32'h0000_1234);
    step();
    bus.RegWrite = 1'b0;
    bus.ReadReg1 = 5'd8;
    bus.ReadReg2 = 5'd9;
    bus.DbgReg   = 5'd9;
    expect_val(P_RD1, 32'hDEAD_BEEF, "basic_r8");
    expect_val(P_RD2, 32'h0000_1234, "basic_r9");
    expect_val(P_DBG, 32'h0000_1234, "basic_dbg_r9");
    expect_val(P_CNT, 32'd2, "basic_cnt");
    step();

    // Writes to register 0 are discarded and not counted.
    wr(5'd0, 32'hFFFF_FFFF);
    bus.ReadReg1 = 5'd0;
    expect_val(P_RD1, 32'h0, "r0_during_write");
    step();
    bus.RegWrite = 1'b0;
    expect_val(P_RD1, 32'h0, "r0_after_write");
    expect_val(P_CNT, 32'd2, "r0_cnt");
    step();

    // Read-during-write on reg 5.
    wr(5'd5, 32'h1);
    step();
    wr(5'd5, 32'h2);
    bus.ReadReg1 = 5'd5;
    bus.ReadReg2 = 5'd6;
    bus.DbgReg   = 5'd5;
`ifdef REGFILE_BYPASS_EN
    rdw_pre = 32'h2;
`else
    rdw_pre = 32'h1;
`endif
    expect_val(P_RD1, rdw_pre, "rdw_pre_rd1");
    expect_val(P_DBG, rdw_pre, "rdw_pre_dbg");
    expect_val(P_RD2, 32'h0, "rdw_other_idx");
    step();
    bus.RegWrite = 1'b0;
    expect_val(P_RD1, 32'h2, "rdw_post_rd1");
    expect_val(P_CNT, 32'd4, "rdw_cnt");
    step();

    // All three ports on the same register.
    bus.ReadReg1 = 5'd8;
    bus.ReadReg2 = 5'd8;
    bus.DbgReg   = 5'd8;
    expect_val(P_RD1, 32'hDEAD_BEEF, "same_rd1");
    expect_val(P_RD2, 32'hDEAD_BEEF, "same_rd2");
    expect_val(P_DBG, 32'hDEAD_BEEF, "same_dbg");
    step();

    // RegWrite=0 ignores WriteReg/WriteData.
    bus.RegWrite  = 1'b0;
    bus.WriteReg  = 5'd8;
    bus.WriteData = 32'h0BAD_0BAD;
    step();
    expect_val(P_RD1, 32'hDEAD_BEEF, "nowrite_r8");
    expect_val(P_CNT, 32'd4, "nowrite_cnt");
    step();

    // Mid-run reset with a write to reg 3 pending; checked before any edge.
    wr(5'd3, 32'hAAAA_AAAA);
    bus.ReadReg1 = 5'd8;
    bus.ReadReg2 = 5'd29;
    bus.DbgReg   = 5'd5;
    Reset_n = 1'b0;
    expect_val(P_RD1, 32'h0, "rst_async_r8");
    expect_val(P_RD2, SP_VAL, "rst_async_sp");
    expect_val(P_DBG, 32'h0, "rst_async_r5");
    expect_val(P_CNT, 32'h0, "rst_async_cnt");
    step();
    step();
    step();
    bus.RegWrite = 1'b0;
    Reset_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.ReadReg1 = 5'(i);
      bus.DbgReg   = 5'(31 - i);
      expect_val(P_RD1, (i == 29) ? SP_VAL : 32'h0, $sformatf("rst_sweep_r%0d", i));
      expect_val(P_DBG, ((31 - i) == 29) ? SP_VAL : 32'h0, $sformatf("rst_sweep_dbg_r%0d", 31 - i));
      step();
    end
    expect_val(P_CNT, 32'h0, "rst_cnt");
    step();

    // Counter saturation on reg 1.
    for (int n = 1; n <= 65534; n++) begin
      wr(5'd1, 32'(n));
      step();
    end
    bus.RegWrite = 1'b0;
    bus.ReadReg1 = 5'd1;
    expect_val(P_CNT, 32'h0000_FFFE, "sat_cnt_fffe");
    expect_val(P_RD1, 32'd65534, "sat_r1_mid");
    step();
    for (int k = 0; k < 6; k++) begin
      bus.RegWrite  = (k % 2 == 0);
      bus.WriteReg  = 5'd1;
      bus.WriteData = 32'h5000_0000 + 32'(k);
      step();
      if (k == 1) expect_val(P_CNT, 32'h0000_FFFF, "sat_cnt_reach");
    end
    bus.RegWrite = 1'b0;
    expect_val(P_CNT, 32'h0000_FFFF, "sat_cnt_hold");
    expect_val(P_RD1, 32'h5000_0004, "sat_r1_last");
    step();
    step();

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry general-purpose register file for the MIPS single-cycle datapath.
- Two combinational read ports feed the ALU and the ALUSrc operand mux.
- One synchronous write port consumes the RegDst-selected 5-bit destination and the MemtoReg-selected 32-bit write-back value.
- Also provides a debug read port and a committed-write counter for bench and trace use.

Parameters:
- DATA_WIDTH, 32: register width in bits.
- ADDR_WIDTH, 5: register index width; the file holds 2**ADDR_WIDTH entries.
- CNT_WIDTH, 16: width of WriteCount.
- SP_RESET, 32'h7FFF_EFFC: reset value of register 29 ($sp).

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- ReadReg1  input  ADDR_WIDTH  read port 1 index (rs).
- ReadReg2  input  ADDR_WIDTH  read port 2 index (rt).
- WriteReg  input  ADDR_WIDTH  write index, from the RegDst 5-bit mux.
- WriteData  input  DATA_WIDTH  write value, from the MemtoReg mux.
- RegWrite  input  1  write enable from the control unit.
- DbgReg  input  ADDR_WIDTH  debug read index.
- ReadData1  output  DATA_WIDTH  contents of ReadReg1.
- ReadData2  output  DATA_WIDTH  contents of ReadReg2.
- DbgData  output  DATA_WIDTH  contents of DbgReg.
- WriteCount  output  CNT_WIDTH  number of committed writes since reset.

Behaviour:
- Reset:
  - Reset_n low immediately clears all registers to 0, except reg 29, which loads SP_RESET.
  - WriteCount clears to 0. This is asynchronous and needs no clock edge.
  - While Reset_n is low, every rising edge of Clk is ignored.
  - A write whose edge coincides with Reset_n low is lost.
  - Release takes effect on the first rising edge with Reset_n high.
- Reads:
  - Combinational, zero latency.
  - ReadData1, ReadData2 and DbgData track their index inputs within the same cycle.
  - Index 0 always reads 0.
- Write commit:
  - A write commits on the rising edge of Clk when Reset_n=1, RegWrite=1 and WriteReg!=0.
  - The register at WriteReg takes WriteData.
  - A write is visible on the read ports after that edge; same-cycle read-during-write follows the Optional Feature rules.
- Register 0:
  - Hardwired to zero; it has no storage.
  - A write to index 0 is discarded and is not counted.
- RegWrite=0: no state change; WriteData and WriteReg are don't-care.
- WriteCount:
  - Increments by 1 on every committed write.
  - Saturates at all-ones: from 16'hFFFF it stays at 16'hFFFF and never wraps.
- Simultaneous read and write of the same index: see Optional Feature.
- Both read ports and the debug port may address the same register at once; all return identical data.
- X on RegWrite when Reset_n=1 is a bench error. The RTL need not define behaviour for it.
- No internal pipelining: single-cycle CPI is preserved.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through bypass.
  - When RegWrite=1, WriteReg!=0 and a read index equals WriteReg, that port returns WriteData combinationally in the same cycle.
  - Applies to ReadData1, ReadData2 and DbgData.
- Undefined:
  - Ports return the stored (old) value until the commit edge.
  - WriteData has no combinational path to any read output.
- Storage, reset, WriteCount and the register-0 rules are identical in both builds.

Test Plan:
- Reset: hold Reset_n=0 for 3 cycles mid-run after writes -> all reads 0 except reg 29 = 32'h7FFF_EFFC; WriteCount=0; asserts without a clock edge.
- Basic write/read:
  - Write 32'hDEAD_BEEF to reg 8, then 32'h0000_1234 to reg 9.
  - Set ReadReg1=8, ReadReg2=9 -> ReadData1=32'hDEAD_BEEF, ReadData2=32'h0000_1234; WriteCount=2.
- Register 0: RegWrite=1, WriteReg=0, WriteData=32'hFFFF_FFFF for one edge -> ReadData1 at index 0 reads 0; WriteCount unchanged.
- Read-during-write:
  - Reg 5 holds 32'h1, then write 32'h2 to reg 5 with ReadReg1=5.
  - Before the edge -> 32'h1 (no bypass) or 32'h2 (REGFILE_BYPASS_EN).
  - After the edge -> 32'h2 in both builds.
- Saturation:
  - Run 65537 writes to reg 1 with RegWrite gated on for alternate cycles -> WriteCount=16'hFFFF and holds there.
  - Reg 1 equals the last value written.
- Reset mid-write: assert Reset_n low at the same edge as a write of 32'hAAAA_AAAA to reg 3 -> reg 3 reads 0 after release; WriteCount=0.
